fir_out_buffer: RTL and testbench

- Elastic output buffer directly downstream of myfir.
- Accepts the FIR output stream (DOUT/VOUT of myfir, no backpressure) and holds samples in a small FIFO.
- Delivers samples to the consumer (data_sink or the next processing stage) with a valid/ready handshake.
- Detects and counts samples lost because the consumer stalled too long.

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_buf_mem.sv | 41 ++++
 rtl/fir_out_buffer.sv | 140 ++++++++++++++
 tb/tb_fir_out_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path.
//   FIR_WIDTH       - sample width of the FIR data path
//   FIR_OBUF_DEPTH  - default depth of the FIR output buffer
//   FIR_DROP_CNT_W  - width of the dropped-sample counter
//   sample_t        - signed FIR sample
package fir_pkg;
    localparam int FIR_WIDTH      = 16;
    localparam int FIR_OBUF_DEPTH = 8;
    localparam int FIR_DROP_CNT_W = 8;

    typedef logic signed [FIR_WIDTH-1:0] sample_t;
endpackage

// File: rtl/fir_buf_mem.sv
// Storage array for the FIR output buffer: DEPTH x WIDTH registers,
// one synchronous write port and one asynchronous read port. Contents
// are never reset; validity is tracked by the owner's occupancy count.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module fir_buf_mem
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int DEPTH = FIR_OBUF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // One write-decoded register per entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_buffer.sv
// Elastic first-word-fall-through buffer between myfir (no backpressure)
// and a valid/ready consumer. Samples arriving while the buffer is full
// and not being drained are dropped, flagged (sticky OVF) and counted
// (saturating DROP_CNT).
// Ports:
//   CLK      - clock, rising edge
//   RST      - synchronous active-high reset
//   DIN/VIN  - sample and valid from myfir
//   RDY      - consumer ready
//   DOUT     - head-of-FIFO sample (0 when empty)
//   VOUT     - output valid (= !EMPTY)
//   FULL     - buffer holds DEPTH samples
//   EMPTY    - buffer holds no samples
//   COUNT    - occupancy 0..DEPTH
//   OVF      - sticky overflow flag
//   CLR_OVF  - clears OVF and DROP_CNT (a simultaneous drop wins)
//   DROP_CNT - dropped-sample count, saturating at 255
module fir_out_buffer
    import fir_pkg::*;
#(
    parameter  int WIDTH = FIR_WIDTH,
    parameter  int DEPTH = FIR_OBUF_DEPTH,   // power of 2, >= 2
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [WIDTH-1:0]          DIN,
    input  logic                      VIN,
    input  logic                      RDY,
    output logic [WIDTH-1:0]          DOUT,
    output logic                      VOUT,
    output logic                      FULL,
    output logic                      EMPTY,
    output logic [AW:0]               COUNT,
    output logic                      OVF,
    input  logic                      CLR_OVF,
    output logic [FIR_DROP_CNT_W-1:0] DROP_CNT
);

    localparam logic [AW:0]                 CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]                 CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]               PTR_ONE  = AW'(1);
    localparam logic [FIR_DROP_CNT_W-1:0]   DROP_MAX = '1;
    localparam logic [FIR_DROP_CNT_W-1:0]   DROP_ONE = FIR_DROP_CNT_W'(1);

    logic [AW-1:0]               rd_ptr_reg,   rd_ptr_next;
    logic [AW-1:0]               wr_ptr_reg,   wr_ptr_next;
    logic [AW:0]                 count_reg,    count_next;
    logic                        ovf_reg,      ovf_next;
    logic [FIR_DROP_CNT_W-1:0]   drop_cnt_reg, drop_cnt_next;

    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] rd_data;

    // Flags come only from the registered count, so VIN never reaches FULL.
    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);

    assign pop  = !empty && RDY;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push = VIN && (!full || pop);
    assign drop = VIN && full && !pop;

    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        ovf_next      = ovf_reg;
        drop_cnt_next = drop_cnt_reg;

        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - CNT_ONE;
        end

        // Clear first, then let a drop in the same cycle override it so the
        // dropped sample is never lost from the statistics.
        if (CLR_OVF) begin
            ovf_next      = 1'b0;
            drop_cnt_next = '0;
        end
        if (drop) begin
            ovf_next = 1'b1;
            if (CLR_OVF) begin
                drop_cnt_next = DROP_ONE;
            end else if (drop_cnt_reg != DROP_MAX) begin
                drop_cnt_next = drop_cnt_reg + DROP_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            ovf_reg      <= ovf_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    fir_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (push && !RST),
        .waddr (wr_ptr_reg),
        .wdata (DIN),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    assign VOUT     = !empty;
    assign DOUT     = empty ? '0 : rd_data;
    assign FULL     = full;
    assign EMPTY    = empty;
    assign COUNT    = count_reg;
    assign OVF      = ovf_reg;
    assign DROP_CNT = drop_cnt_reg;

endmodule

// File: tb/tb_fir_out_buffer.sv
module tb_fir_out_buffer;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        vin;
    logic        rdy;
    logic        clr_ovf;
    logic [15:0] dout;
    logic        vout;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    fir_out_buffer dut (
        .CLK      (clk),
        .RST      (rst),
        .DIN      (din),
        .VIN      (vin),
        .RDY      (rdy),
        .DOUT     (dout),
        .VOUT     (vout),
        .FULL     (full),
        .EMPTY    (empty),
        .COUNT    (count),
        .OVF      (ovf),
        .CLR_OVF  (clr_ovf),
        .DROP_CNT (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] v, input bit expect_out);
        din = v;
        vin = 1'b1;
        if (expect_out) exp_q.push_back(v);
        step();
        vin = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vin = 1'b1; din = 16'h1234; rdy = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; vin = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        chk("rst_vout",  32'(vout), 0);
        chk("rst_dout",  32'(dout), 0);
        chk("rst_ovf",   32'(ovf), 0);
        chk("rst_drop",  32'(drop_cnt), 0);

        // Scoreboard monitor: a transfer happens at the next edge whenever
        // VOUT and RDY are both high at the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (!rst && vout && rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pop", 32'(dout), 32'hFFFF_FFFF);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        $display("pop dout=%04h expected=%04h", dout, e);
                        chk("pop_data", 32'(dout), 32'(e));
                    end
                end
            end
        join_none

        // Pass-through with one-cycle latency.
        rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din = 16'(i); vin = 1'b1; exp_q.push_back(16'(i));
            step();
            chk("pt_vout",  32'(vout), 1);
            chk("pt_dout",  32'(dout), 32'(i));
            chk("pt_count", 32'(count), 1);
        end
        vin = 1'b0;
        step();
        chk("pt_empty", 32'(empty), 1);

        // Fill and stall.
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) push_one(16'h0010 + 16'(i), 1'b1);
        chk("fill_full",  32'(full), 1);
        chk("fill_count", 32'(count), 8);
        chk("fill_dout",  32'(dout), 32'h10);
        step();
        chk("hold_dout", 32'(dout), 32'h10);
        chk("hold_vout", 32'(vout), 1);

        // Overflow: these three never reach the scoreboard.
        for (int i = 0; i < 3; i++) push_one(16'h00AA + 16'(i), 1'b0);
        chk("ovf_flag",  32'(ovf), 1);
        chk("ovf_drop",  32'(drop_cnt), 3);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_dout",  32'(dout), 32'h10);

        // Full with simultaneous push and pop: accepted, no drop.
        rdy = 1'b1;
        push_one(16'h0100, 1'b1);
        chk("pp_count", 32'(count), 8);
        chk("pp_drop",  32'(drop_cnt), 3);
        chk("pp_full",  32'(full), 1);
        repeat (8) step();
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // Clear, then refill (pointers now wrapped) and drop 5.
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("clr_ovf",  32'(ovf), 0);
        chk("clr_drop", 32'(drop_cnt), 0);
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) push_one(16'h0020 + 16'(i), 1'b1);
        for (int i = 0; i < 5; i++) push_one(16'h00B0 + 16'(i), 1'b0);
        chk("d5_drop", 32'(drop_cnt), 5);

        // Clear together with a drop: the drop wins.
        clr_ovf = 1'b1;
        push_one(16'h00BF, 1'b0);
        chk("cd_ovf",  32'(ovf), 1);
        chk("cd_drop", 32'(drop_cnt), 1);
        step();
        clr_ovf = 1'b0;
        chk("c_ovf",  32'(ovf), 0);
        chk("c_drop", 32'(drop_cnt), 0);

        // Saturation of the drop counter.
        din = 16'h00CC; vin = 1'b1;
        repeat (260) step();
        vin = 1'b0;
        chk("sat_drop", 32'(drop_cnt), 255);
        chk("sat_dout", 32'(dout), 32'h20);

        // Drain part of the FIFO, then reset mid-operation.
        rdy = 1'b1;
        repeat (2) step();
        rdy = 1'b0;
        chk("part_count", 32'(count), 6);
        rst = 1'b1; step(); rst = 1'b0;
        exp_q.delete();
        chk("mrst_count", 32'(count), 0);
        chk("mrst_empty", 32'(empty), 1);
        chk("mrst_ovf",   32'(ovf), 0);
        chk("mrst_drop",  32'(drop_cnt), 0);
        chk("mrst_dout",  32'(dout), 0);

        rdy = 1'b1;
        push_one(16'h0055, 1'b1);
        chk("post_dout", 32'(dout), 32'h55);

        // Bounded wait for the scoreboard to drain.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("sb_leftover", 32'(exp_q.size()), 0);
        step();
        chk("end_empty", 32'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
